// File: rtl/tx_gearbox_66b.sv
// tx_gearbox_66b: packs 2-bit sync header + 64-bit payload into a continuous DATA_WIDTH-bit PMA stream.
// Define GB_HDR_CHECK_EN to flag illegal sync headers (00/11) and replace them with 2'b10 before packing.
module tx_gearbox_66b #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_hdr,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_underflow,
    output logic                  o_hdr_err
);
    localparam int W  = DATA_WIDTH;
    localparam int AW = 2 * W + 2;

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
        $error("tx_gearbox_66b: DATA_WIDTH must be 32 or 64");
    end

    logic [5:0]    seq;
    logic          phase;
    logic [7:0]    fill;
    logic [AW-1:0] acc;
    logic          pause, accept, emit, hdr_beat;
    logic [1:0]    hdr_use;
    logic [AW-1:0] in_ext, merged, acc_n;
    logic [7:0]    fill_n;
    logic [W-1:0]  word;

    assign pause    = seq == 6'd32;
    assign o_ready  = ~pause;
    assign accept   = i_valid & o_ready;
    assign emit     = accept | pause;
    assign hdr_beat = (W == 64) || !phase;

`ifdef GB_HDR_CHECK_EN
    logic hdr_bad;
    assign hdr_bad = hdr_beat && (i_hdr == 2'b00 || i_hdr == 2'b11);
    assign hdr_use = hdr_bad ? 2'b10 : i_hdr;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) o_hdr_err <= 1'b0;
        else            o_hdr_err <= accept & hdr_bad;
    end
`else
    assign hdr_use   = i_hdr;
    assign o_hdr_err = 1'b0;
`endif

    // New bits land directly above the fill residual bits; the pause cycle drains exactly one word.
    assign in_ext = hdr_beat ? AW'({i_data, hdr_use}) : AW'(i_data);
    assign merged = acc | (in_ext << fill);
    assign acc_n  = pause ? acc >> W : merged >> W;
    assign fill_n = pause ? fill - 8'(W) : fill + (hdr_beat ? 8'd2 : 8'd0);
    assign word   = pause ? acc[W-1:0] : merged[W-1:0];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            seq          <= '0;
            phase        <= 1'b0;
            fill         <= '0;
            acc          <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_underflow  <= 1'b0;
        end else begin
            seq          <= pause ? 6'd0 : seq + {5'd0, accept};
            phase        <= phase ^ accept;
            if (emit) begin
                acc    <= acc_n;
                fill   <= fill_n;
                o_data <= word;
            end
            o_data_valid <= emit;
            o_underflow  <= o_ready & ~i_valid;
        end
    end
endmodule
